sd_cand_gen: RTL

Parametrised successor to the fixed 9x9 Sudoku front end. Loads a (BOX*BOX)x(BOX*BOX) grid streamed in row-major order, where value 0 marks a blank cell. While loading, it builds row, column and box occupancy masks. It then streams one candidate bitmask per blank cell to the downstream solver core through a valid/ready handshake, and reports duplicate or illegal givens.

---
 rtl/sd_cand_gen.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/sd_cand_gen.sv
// sd_cand_gen: Sudoku front end. Loads a (BOX*BOX)x(BOX*BOX) grid in row-major order
// (0 = blank), builds row/column/box occupancy masks while loading, then streams one
// candidate mask per blank cell over a valid/ready handshake and flags bad givens.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_valid, in      cell strobe and value (0 = blank, 1..N = given)
//   out_valid/ready   candidate beat handshake
//   out_idx           row-major index of the blank cell
//   out_cand          candidate mask, bit v-1 set = value v is legal
//   out_last          final blank beat of the grid
//   out_done          one-cycle pulse when the grid is finished
//   conflict          duplicate or illegal given seen; valid while out_done=1
//   out_single        exactly one candidate bit set (only with SD_SINGLE_EN)
//
// Optional feature: define SD_SINGLE_EN to build the popcount behind out_single;
// otherwise out_single is tied to 0.
module sd_cand_gen #(
  parameter int unsigned BOX = 3,
  parameter int unsigned VW  = 4,
  parameter int unsigned IW  = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [VW-1:0]        in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IW-1:0]        out_idx,
  output logic [BOX*BOX-1:0]   out_cand,
  output logic                 out_last,
  output logic                 out_done,
  output logic                 conflict,
  output logic                 out_single
);

  localparam int unsigned N  = BOX * BOX;
  localparam int unsigned C  = N * N;
  localparam int unsigned NW = $clog2(N);
  localparam int unsigned BW = $clog2(BOX);

  localparam logic [NW-1:0] NLast   = NW'(N - 1);
  localparam logic [NW-1:0] NwOne   = NW'(1);
  localparam logic [NW-1:0] BoxStep = NW'(BOX);
  localparam logic [BW-1:0] BLast   = BW'(BOX - 1);
  localparam logic [BW-1:0] BwOne   = BW'(1);
  localparam logic [IW-1:0] CLast   = IW'(C - 1);
  localparam logic [IW-1:0] KOne    = IW'(1);
  localparam logic [IW:0]   CntOne  = (IW + 1)'(1);
  localparam logic [VW-1:0] NVal    = VW'(N);
  localparam logic [VW-1:0] VOne    = VW'(1);
  localparam logic [N-1:0]  NOne    = {{(N - 1){1'b0}}, 1'b1};
  localparam logic [C-1:0]  COne    = {{(C - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StLoad, StEmit, StDone} state_e;

  state_e          state;
  logic [IW-1:0]   k;          // cell counter while loading, scan pointer while emitting
  logic [NW-1:0]   r, c, b;    // row, column and box of cell k
  logic [NW-1:0]   box_base;   // box index of the first box in the current box row
  logic [BW-1:0]   cib, rib;   // column / row position inside the current box
  logic [C-1:0]    blank;
  logic [IW:0]     nblank;     // blanks loaded, then blanks still to emit
  logic [N-1:0]    row_mask [N];
  logic [N-1:0]    col_mask [N];
  logic [N-1:0]    box_mask [N];

  logic [N-1:0]    used, vbit;
  logic            given, illegal, cur_blank;
  logic [VW-1:0]   vm1;
  logic [C-1:0]    blank_sh;
  logic [NW-1:0]   r_n, c_n, b_n, base_n;
  logic [BW-1:0]   cib_n, rib_n;

  always_comb begin
    used      = row_mask[r] | col_mask[c] | box_mask[b];
    given     = (in != '0) && (in <= NVal);
    illegal   = in > NVal;
    vm1       = in - VOne;
    vbit      = given ? (NOne << vm1) : '0;
    blank_sh  = blank >> k;
    cur_blank = blank_sh[0];

    // Step row/column/box to the next row-major cell without division.
    c_n    = c + NwOne;
    cib_n  = cib + BwOne;
    r_n    = r;
    rib_n  = rib;
    b_n    = b;
    base_n = box_base;
    if (cib == BLast) begin
      cib_n = '0;
      b_n   = b + NwOne;
    end
    if (c == NLast) begin
      c_n   = '0;
      cib_n = '0;
      r_n   = r + NwOne;
      if (rib == BLast) begin
        rib_n  = '0;
        base_n = box_base + BoxStep;
        b_n    = box_base + BoxStep;
      end else begin
        rib_n = rib + BwOne;
        b_n   = box_base;
      end
    end
  end

  always_comb begin
    out_valid = (state == StEmit) && (nblank != '0) && cur_blank;
    out_idx   = out_valid ? k : '0;
    out_cand  = out_valid ? ~used : '0;
    out_last  = out_valid && (nblank == CntOne);
    out_done  = (state == StDone);
`ifdef SD_SINGLE_EN
    out_single = out_valid && ($countones(out_cand) == 1);
`else
    out_single = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      k        <= '0;
      r        <= '0;
      c        <= '0;
      b        <= '0;
      box_base <= '0;
      cib      <= '0;
      rib      <= '0;
      blank    <= '0;
      nblank   <= '0;
      conflict <= 1'b0;
      for (int i = 0; i < N; i++) begin
        row_mask[i] <= '0;
        col_mask[i] <= '0;
        box_mask[i] <= '0;
      end
    end else begin
      unique case (state)
        StIdle, StLoad: begin
          if (in_valid) begin
            if (illegal || ((used & vbit) != '0)) conflict <= 1'b1;
            row_mask[r] <= row_mask[r] | vbit;
            col_mask[c] <= col_mask[c] | vbit;
            box_mask[b] <= box_mask[b] | vbit;
            if (in == '0) begin
              blank  <= blank | (COne << k);
              nblank <= nblank + CntOne;
            end
            if (k == CLast) begin
              state    <= StEmit;
              k        <= '0;
              r        <= '0;
              c        <= '0;
              b        <= '0;
              box_base <= '0;
              cib      <= '0;
              rib      <= '0;
            end else begin
              state    <= StLoad;
              k        <= k + KOne;
              r        <= r_n;
              c        <= c_n;
              b        <= b_n;
              box_base <= base_n;
              cib      <= cib_n;
              rib      <= rib_n;
            end
          end
        end
        StEmit: begin
          if (nblank == '0) begin
            state <= StDone;
          end else if (!cur_blank || out_ready) begin
            if (cur_blank) nblank <= nblank - CntOne;
            if (cur_blank && (nblank == CntOne)) begin
              state <= StDone;
            end else begin
              k        <= k + KOne;
              r        <= r_n;
              c        <= c_n;
              b        <= b_n;
              box_base <= base_n;
              cib      <= cib_n;
              rib      <= rib_n;
            end
          end
        end
        StDone: begin
          state    <= StIdle;
          k        <= '0;
          r        <= '0;
          c        <= '0;
          b        <= '0;
          box_base <= '0;
          cib      <= '0;
          rib      <= '0;
          blank    <= '0;
          nblank   <= '0;
          conflict <= 1'b0;
          for (int i = 0; i < N; i++) begin
            row_mask[i] <= '0;
            col_mask[i] <= '0;
            box_mask[i] <= '0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
